// File: rtl/mux_scan_sel_pkg.sv
// Shared types and helpers for the N-channel scanning word selector.
package mux_scan_pkg;

    // Effective operating mode, decoded each cycle from hold/auto_en.
    typedef enum logic [1:0] {
        MODE_MANUAL = 2'd0,
        MODE_AUTO   = 2'd1,
        MODE_HOLD   = 2'd2
    } mode_t;

    // Channel index width; a single channel still needs one bit.
    function automatic int sel_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/mux_scan_sel_if.sv
// Data/control bundle between a board top (master) and the selector (slave).
interface mux_scan_sel_if
    import mux_scan_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4
) ();
    localparam int SEL_W = sel_w(CHANNELS);

    logic [CHANNELS*WIDTH-1:0] data_in;
    logic [SEL_W-1:0]          sel_in;
    logic                      auto_en;
    logic                      hold;
    logic [WIDTH-1:0]          data_out;
    logic [SEL_W-1:0]          ch_out;
    logic                      ch_change;

    modport master (
        output data_in, sel_in, auto_en, hold,
        input  data_out, ch_out, ch_change
    );

    modport slave (
        input  data_in, sel_in, auto_en, hold,
        output data_out, ch_out, ch_change
    );
endinterface

// File: rtl/mux_scan_sel_prescaler.sv
// Free-running divider that flags the last count of every TICK_DIV-edge period.
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int            CW   = $clog2(TICK_DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == LAST);
    // A clear on the same edge suppresses the tick so a restart never advances.
    assign tick   = en && !clr && w_last;

    // Count while enabled, wrap on the last value; clear wins over enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/mux_scan_sel.sv
// Registered N:1 word selector with manual select, timed auto-scan and hold.
module mux_scan_sel
    import mux_scan_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int TICK_DIV = 50_000_000
) (
    input logic           clk,
    input logic           rst,
    mux_scan_sel_if.slave bus
);
    localparam int             SEL_W   = sel_w(CHANNELS);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

    logic [CHANNELS-1:0][WIDTH-1:0] w_words;
    mode_t                          w_mode;
    mode_t                          r_state;
    logic                           w_entry;
    logic                           w_tick;
    logic [SEL_W-1:0]               w_ch_next;
    logic [SEL_W-1:0]               r_ch;
    logic [WIDTH-1:0]               r_data;
    logic                           r_chg;

    assign w_words = bus.data_in;

    // Hold overrides auto, auto overrides manual.
    always_comb begin
        w_mode = MODE_MANUAL;
        if (bus.hold)         w_mode = MODE_HOLD;
        else if (bus.auto_en) w_mode = MODE_AUTO;
    end

    // Any cycle entering AUTO restarts the scan period.
    assign w_entry = (w_mode == MODE_AUTO) && (r_state != MODE_AUTO);

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_entry),
        .en   (w_mode == MODE_AUTO),
        .tick (w_tick)
    );

    // Next channel: valid manual request, or round-robin step on a tick.
    always_comb begin
        w_ch_next = r_ch;
        case (w_mode)
            MODE_MANUAL: if (int'(bus.sel_in) < CHANNELS) w_ch_next = bus.sel_in;
            MODE_AUTO:   if (w_tick) w_ch_next = (r_ch == LAST_CH) ? '0 : r_ch + 1'b1;
            default:     w_ch_next = r_ch;
        endcase
    end

    // Output registers: channel, live word and change strobe move together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= MODE_MANUAL;
            r_ch    <= '0;
            r_data  <= '0;
            r_chg   <= 1'b0;
        end else begin
            r_state <= w_mode;
            if (w_mode != MODE_HOLD) begin
                r_ch   <= w_ch_next;
                r_data <= w_words[w_ch_next];
                r_chg  <= (w_ch_next != r_ch);
            end else begin
                r_chg  <= 1'b0;
            end
        end
    end

    assign bus.data_out  = r_data;
    assign bus.ch_out    = r_ch;
    assign bus.ch_change = r_chg;
endmodule

// File: tb/tb_mux_scan_sel.sv
// Directed bench for mux_scan_sel: 3 channels of 4 bits, scan period of 4 edges.
module tb_mux_scan_sel;
    typedef struct packed {
        logic [3:0] d;
        logic [1:0] ch;
        logic       chg;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst;
    exp_t   sb[$];
    string  tags[$];
    int     n_chk  = 0;
    int     n_fail = 0;

    mux_scan_sel_if #(.WIDTH(4), .CHANNELS(3)) bus ();

    mux_scan_sel #(.WIDTH(4), .CHANNELS(3), .TICK_DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Queue the expected outputs for the coming edge, then check after it.
    task automatic cyc(input logic [3:0] d, input logic [1:0] ch, input logic chg, input string tag);
        exp_t e;
        string t;
        sb.push_back('{d: d, ch: ch, chg: chg});
        tags.push_back(tag);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        t = tags.pop_front();
        n_chk++;
        assert (bus.data_out === e.d) else begin
            n_fail++;
            $error("FAIL %s data_out: got %h want %h", t, bus.data_out, e.d);
        end
        n_chk++;
        assert (bus.ch_out === e.ch) else begin
            n_fail++;
            $error("FAIL %s ch_out: got %0d want %0d", t, bus.ch_out, e.ch);
        end
        n_chk++;
        assert (bus.ch_change === e.chg) else begin
            n_fail++;
            $error("FAIL %s ch_change: got %b want %b", t, bus.ch_change, e.chg);
        end
    endtask

    task automatic set_ch1(input logic [3:0] v);
        bus.data_in[7:4] = v;
    endtask

    initial begin
        rst         = 1'b1;
        bus.data_in = {4'hC, 4'hB, 4'hA};
        bus.sel_in  = 2'd0;
        bus.auto_en = 1'b1;
        bus.hold    = 1'b0;
        #1;

        // Reset with live data and auto enabled
        cyc(4'h0, 2'd0, 1'b0, "reset0");
        cyc(4'h0, 2'd0, 1'b0, "reset1");

        // Manual select of ch2, then an out-of-range request is ignored
        rst = 1'b0; bus.auto_en = 1'b0; bus.sel_in = 2'd2;
        cyc(4'hC, 2'd2, 1'b1, "man_sel2");
        cyc(4'hC, 2'd2, 1'b0, "man_sel2_hold");
        bus.sel_in = 2'd3;
        cyc(4'hC, 2'd2, 1'b0, "man_oor0");
        cyc(4'hC, 2'd2, 1'b0, "man_oor1");

        // Auto entry: 4 edges on ch2, then 0,1,2,0,1 every 4 edges
        bus.auto_en = 1'b1;
        for (int i = 0; i < 4; i++) cyc(4'hC, 2'd2, 1'b0, "auto_entry");
        cyc(4'hA, 2'd0, 1'b1, "auto_wrap0");
        for (int i = 0; i < 3; i++) cyc(4'hA, 2'd0, 1'b0, "auto_ch0");
        cyc(4'hB, 2'd1, 1'b1, "auto_step1");
        for (int i = 0; i < 3; i++) cyc(4'hB, 2'd1, 1'b0, "auto_ch1");
        cyc(4'hC, 2'd2, 1'b1, "auto_step2");
        for (int i = 0; i < 3; i++) cyc(4'hC, 2'd2, 1'b0, "auto_ch2");
        cyc(4'hA, 2'd0, 1'b1, "auto_wrap1");
        for (int i = 0; i < 3; i++) cyc(4'hA, 2'd0, 1'b0, "auto_ch0b");
        cyc(4'hB, 2'd1, 1'b1, "auto_step1b");
        cyc(4'hB, 2'd1, 1'b0, "auto_pre_hold");

        // Hold mid-scan while the active channel's word changes
        bus.hold = 1'b1;
        set_ch1(4'h7);
        for (int i = 0; i < 10; i++) cyc(4'hB, 2'd1, 1'b0, "hold_frozen");

        // Release into auto restarts the period; data picks up the new word
        bus.hold = 1'b0;
        cyc(4'h7, 2'd1, 1'b0, "rel_entry");
        for (int i = 0; i < 3; i++) cyc(4'h7, 2'd1, 1'b0, "rel_wait");
        cyc(4'hC, 2'd2, 1'b1, "rel_advance");
        cyc(4'hC, 2'd2, 1'b0, "cnt1");
        cyc(4'hC, 2'd2, 1'b0, "cnt2");

        // Reset mid-scan, then manual ch1 comes up one edge after rst drops
        set_ch1(4'hB);
        rst = 1'b1; bus.auto_en = 1'b0; bus.sel_in = 2'd1;
        cyc(4'h0, 2'd0, 1'b0, "rst_mid");
        rst = 1'b0;
        cyc(4'hB, 2'd1, 1'b1, "post_rst_sel1");

        // Live tracking on a steady manual channel
        cyc(4'hB, 2'd1, 1'b0, "live_steady");
        set_ch1(4'h5);
        cyc(4'h5, 2'd1, 1'b0, "live_track");

        // Hold blocks a manual change; release applies it on that edge
        bus.hold = 1'b1; bus.sel_in = 2'd0;
        cyc(4'h5, 2'd1, 1'b0, "hold_man0");
        cyc(4'h5, 2'd1, 1'b0, "hold_man1");
        bus.hold = 1'b0;
        cyc(4'hA, 2'd0, 1'b1, "rel_manual");
        cyc(4'hA, 2'd0, 1'b0, "rel_manual_q");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
